mem_ring_ctrl: RTL
==================

Name: mem_ring_ctrl

Overview:
- Controller and arbiter for the 16 x 8 single-address-port buffer memory in the UART datapath.
- Operates the memory as a circular FIFO shared between two requesters: a producer (RX side) that writes bytes and a consumer (TX side) that reads them.
- Schedules at most one memory access per transaction, round-robins between the requesters under contention, and tracks the pointers, occupancy and full/empty flags.

Parameters:
AW, 4, memory address width; DEPTH = 2**AW entries (16).
DW, 8, data width.

Ports:
clk  input  1  clock.
rst  input  1  reset; one clock; reset is asynchronous and active-low.
wr_req  input  1  producer write request, level, held until wr_ack.
wr_data  input  DW  write byte, stable while wr_req high.
wr_ack  output  1  one-cycle pulse: write performed.
rd_req  input  1  consumer read request, level, held until rd_ack.
rd_ack  output  1  one-cycle pulse: read accepted.
rd_data  output  DW  read byte, valid when rd_valid.
rd_valid  output  1  one-cycle pulse: rd_data holds the popped byte.
flush  input  1  synchronous clear of pointers and count.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
count  output  AW+1  occupancy, 0..DEPTH.
mem_addr  output  AW  to memory addr.
mem_wr_data  output  DW  to memory wr_mem_data.
mem_wr  output  1  to memory wr_mem.
mem_rd  output  1  to memory rd_mem.
mem_rd_data  input  DW  from memory rd_mem_data; registered, valid the cycle after mem_rd.

Behaviour:
- Reset (rst=0, asynchronous, any state):
  - state IDLE; wptr=rptr=0; count=0; empty=1, full=0.
  - All other outputs 0, including rd_data.
  - Last-grant flag = READ, so a write wins the first tie.
  - Memory contents are not touched. The memory's own reset is active-high; the integration level drives it with ~rst.
- Output timing: all mem_* outputs and the ack/valid outputs come from flops (state, pointer and latch registers). There is no combinational path from requests to outputs.
- FSM states:
  - IDLE: evaluate eligibility. we = wr_req & !full; re = rd_req & !empty.
    - flush=1: wptr=rptr=count=0, no grant, stay in IDLE. flush has priority over requests.
    - we only: latch wr_data, go to WR.
    - re only: go to RD.
    - Both: grant the opposite of the last grant, update the flag, go to WR or RD.
    - Neither: stay in IDLE.
  - WR (1 cycle): mem_wr=1, mem_addr=wptr, mem_wr_data=latched byte, wr_ack=1. At the edge: wptr+1 (mod DEPTH, 15 wraps to 0), count+1. Next state IDLE.
  - RD (1 cycle): mem_rd=1, mem_addr=rptr, rd_ack=1. At the edge: rptr+1 (mod DEPTH), count-1. Next state RD_WAIT.
  - RD_WAIT (1 cycle): mem_rd_data is valid; capture it into rd_data at the edge. Next state IDLE, with rd_valid=1 in that IDLE cycle.
- Latency, with the grant decided in IDLE cycle T:
  - Write: wr_ack and mem_wr in T+1.
  - Read: rd_ack and mem_rd in T+1; rd_valid in T+3.
  - rd_data holds its value until the next capture.
- Throughput: a new transaction may be granted in the same IDLE cycle that shows rd_valid. Best case is one write per 2 cycles and one read per 3 cycles.
- Requester contract: deassert or re-present the request the cycle after the ack. wr_req/rd_req seen high in IDLE after an ack counts as a new request.
- Full: wr_req is held off with no ack and no memory access; the write proceeds after a read frees an entry.
- Empty: rd_req is held off likewise.
- count changes only in WR or RD, so increment and decrement never coincide.
- full/empty are derived from count (registered) and reflect the update the cycle after WR/RD.
- flush outside IDLE: the current WR/RD/RD_WAIT completes normally (including rd_valid). The flush takes effect in the next IDLE only if still asserted.
- Reset during RD_WAIT aborts the read: no rd_valid, rd_data=0.

Test Plan:
- Reset: assert rst=0 during RD_WAIT -> rd_valid never pulses, rd_data=0, count=0, empty=1, mem_wr=mem_rd=0.
- Basic order: write 0xA5 then 0x3C, then two reads -> mem_wr at addr 0 and 1; rd_data 0xA5 then 0x3C; each rd_valid exactly 3 cycles after its IDLE grant cycle.
- Full/wrap: 16 writes -> full=1, count=16. A 17th wr_req gets no ack; after one read it is acked and written at addr 0 (wptr wrap). Reading all 16 returns bytes in FIFO order across the wrap.
- Contention: count=5, both requests held continuously -> grants alternate W,R,W,R starting with W after reset; count returns to 5 after 2 pairs.
- Empty hold: rd_req with count=0 -> no rd_ack and no mem_rd. A write of 0x77 then proceeds; the following read returns 0x77.
- Flush: count=7, flush pulsed in IDLE -> count=0, empty=1. Next write goes to addr 0. Flush asserted during WR -> the write completes with count=8, then clears to 0 in the next IDLE.

Source files
------------

// File: rtl/mem_ring_ctrl.sv
// mem_ring_ctrl: arbiter and pointer controller that runs a 16x8 single-port
// buffer memory as a circular FIFO shared by an RX-side producer (writes) and a
// TX-side consumer (reads). One memory access per transaction; round-robin on
// contention; every output comes straight from a flop.
module mem_ring_ctrl #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    // producer side
    input  logic          wr_req,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ack,
    // consumer side
    input  logic          rd_req,
    output logic          rd_ack,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    // control and status
    input  logic          flush,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    // memory port
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wr_data,
    output logic          mem_wr,
    output logic          mem_rd,
    input  logic [DW-1:0] mem_rd_data
);

    localparam int unsigned DEPTH     = 1 << AW;
    localparam logic [AW:0] CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW:0] CNT_LAST  = (AW + 1)'(DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD      = 2'd2,
        RD_WAIT = 2'd3
    } state_t;

    state_t        state;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    // 1: the last contested grant went to the reader, so the writer wins the next tie
    logic          last_rd;

    // eligibility of each requester, only meaningful while in IDLE
    logic          we_c;
    logic          re_c;
    logic          grant_wr_c;
    logic          grant_rd_c;

    // requester eligibility and round-robin tie break
    always_comb begin
        we_c       = wr_req & ~full;
        re_c       = rd_req & ~empty;
        grant_wr_c = 1'b0;
        grant_rd_c = 1'b0;
        if (we_c && re_c) begin
            grant_wr_c = last_rd;
            grant_rd_c = ~last_rd;
        end else begin
            grant_wr_c = we_c;
            grant_rd_c = re_c;
        end
    end

    // transaction sequencer: pointers, occupancy, flags and memory strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            last_rd     <= 1'b1;
            wr_ack      <= 1'b0;
            rd_ack      <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            mem_wr      <= 1'b0;
            mem_rd      <= 1'b0;
        end else begin
            // strobes are single-cycle pulses
            wr_ack   <= 1'b0;
            rd_ack   <= 1'b0;
            rd_valid <= 1'b0;
            mem_wr   <= 1'b0;
            mem_rd   <= 1'b0;

            case (state)
                IDLE: begin
                    if (flush) begin
                        // flush beats any pending request
                        wptr  <= '0;
                        rptr  <= '0;
                        count <= '0;
                        full  <= 1'b0;
                        empty <= 1'b1;
                    end else if (grant_wr_c) begin
                        if (re_c) begin
                            last_rd <= 1'b0;
                        end
                        mem_wr      <= 1'b1;
                        mem_addr    <= wptr;
                        mem_wr_data <= wr_data;
                        wr_ack      <= 1'b1;
                        state       <= WR;
                    end else if (grant_rd_c) begin
                        if (we_c) begin
                            last_rd <= 1'b1;
                        end
                        mem_rd   <= 1'b1;
                        mem_addr <= rptr;
                        rd_ack   <= 1'b1;
                        state    <= RD;
                    end
                end

                WR: begin
                    // memory write happens this cycle; commit pointer and occupancy
                    wptr  <= wptr + PTR_ONE;
                    count <= count + CNT_ONE;
                    full  <= (count == CNT_LAST);
                    empty <= 1'b0;
                    state <= IDLE;
                end

                RD: begin
                    // read issued this cycle; data arrives from the memory next cycle
                    rptr  <= rptr + PTR_ONE;
                    count <= count - CNT_ONE;
                    full  <= 1'b0;
                    empty <= (count == CNT_ONE);
                    state <= RD_WAIT;
                end

                RD_WAIT: begin
                    rd_data  <= mem_rd_data;
                    rd_valid <= 1'b1;
                    state    <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
